flit_buffer_width_downconverter: RTL and testbench
==================================================

# flit_buffer_width_downconverter

Parametrised buffered width down-converter for the DI–NoC bridge path. It accepts wide flits, each tagged with how many narrow words it carries, and stores them in an internal FIFO. It emits them as RATIO-times narrower flits, least-significant word first. An optional store-and-forward mode holds output until a complete packet is buffered. This block generalises the fixed 32→16-bit flit buffer to arbitrary integer width ratios and adds fill-level reporting.

## Interface
- IN_FLIT_WIDTH, 32, input flit width; must equal RATIO*OUT_FLIT_WIDTH with RATIO ≥ 2.
- OUT_FLIT_WIDTH, 16, output flit width.
- MAX_PKT_LEN, 10, maximum packet length in input flits.
- STORE_AND_FORWARD, 0, 1 = output only when at least one complete packet is buffered.
- DEPTH (localparam), 1<<$clog2(MAX_PKT_LEN+1), FIFO entries. RATIO = IN/OUT. WCNT_W = max(1,$clog2(RATIO)).
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- in_flit_data  in  IN_FLIT_WIDTH  wide flit; word k = bits [k*OUT+:OUT].
- in_flit_valid  in  1  input valid.
- in_flit_last  in  1  last flit of packet.
- in_flit_words  in  WCNT_W  number of valid words; 0 = RATIO (full); values ≥ RATIO are treated as RATIO.
- in_flit_ready  out  1  input ready.
- out_flit_data  out  OUT_FLIT_WIDTH  narrow flit.
- out_flit_valid  out  1  output valid.
- out_flit_last  out  1  last word of last flit of packet.
- out_flit_ready  in  1  output ready.
- fill_level  out  $clog2(DEPTH+1)  wide flits currently stored.
- pkt_count  out  $clog2(DEPTH+1)  complete packets currently stored.

## Operation
- FIFO entry = {last, nwords, data}. nwords is decoded on push to 1..RATIO.
- Push when in_flit_valid & in_flit_ready. in_flit_ready = (fill_level < DEPTH). When full, ready stays low even if a pop occurs in the same cycle.
- Word index widx (0..RATIO-1). out_flit_data = head.data[widx*OUT+:OUT], combinational mux.
- Output transfer = out_flit_valid & out_flit_ready. On transfer:
  - if widx == head.nwords-1: pop head and set widx = 0;
  - otherwise widx++.
- out_flit_last = head.last & (widx == head.nwords-1) & out_flit_valid.
- Words beyond nwords are never emitted. No padding words are generated.
- pkt_count increments on a push with in_flit_last. It decrements on a pop of an entry with last. A simultaneous increment and decrement leaves it unchanged.
- out_flit_valid:
  - STORE_AND_FORWARD=0: !empty.
  - STORE_AND_FORWARD=1: !empty & (pkt_count > 0 | fill_level == DEPTH). The full-FIFO fallback switches to cut-through so an oversize packet cannot deadlock.
- Once out_flit_valid is high it stays high, with data stable, until the transfer completes.
- RATIO is not a power of two: the index wraps at nwords-1, never at 2^k.

## Timing
- Reset values: out_flit_valid 0, out_flit_last 0, in_flit_ready 1, fill_level 0, pkt_count 0, widx 0. The FIFO pointers are cleared; data contents are don't-care.
- Reset mid-packet discards all buffered flits and any partially emitted flit. The first output after reset is word 0 of the first flit pushed after reset.
- Latency: a flit pushed in cycle N is first visible on the output in cycle N+1 (registered FIFO, no fall-through).
- A single full flit occupies RATIO output cycles at full throughput. A flit with nwords=1 takes 1 cycle.
- Sustained rate: one output word per cycle, with no bubble between consecutive flits.
- fill_level and pkt_count update one cycle after the push/pop edge, i.e. they are registered.
- Simultaneous push and pop when not full: fill_level is unchanged.

## Test plan
- RATIO=2, full flit 0xBBBBAAAA with last=1, out ready:
  - out 0xAAAA, then 0xBBBB;
  - out_flit_last only on 0xBBBB;
  - first valid 1 cycle after push.
- RATIO=2, flits {0x1111_2222 words=1, 0x3333_4444 words=0 last=1}:
  - output 0x2222, 0x4444, 0x3333;
  - last on 0x3333.
- IN=48/OUT=16 (RATIO=3), flit 0xCCCC_BBBB_AAAA words=0, then 0x0000_FFFF_EEEE words=2 last:
  - output AAAA, BBBB, CCCC, EEEE, FFFF;
  - last on FFFF.
- Fill DEPTH=16 entries with out_flit_ready=0:
  - in_flit_ready drops after the 16th push; fill_level=16;
  - with push and pop both requested while full, no push occurs.
- STORE_AND_FORWARD=1, 3-flit packet pushed with gaps:
  - out_flit_valid stays 0 until the cycle after the last flit's push;
  - pkt_count goes 0→1→0 after the final word.
- STORE_AND_FORWARD=1, 20-flit packet (exceeds DEPTH):
  - the output starts once fill_level=16 (fallback);
  - all 40 words are delivered in order with no deadlock.
- Assert rst while 3 flits are buffered and widx=1:
  - next cycle out_flit_valid=0, fill_level=0, pkt_count=0;
  - the subsequent new flit's word 0 is output first.

Source files
------------

// File: rtl/flit_buffer_width_downconverter.sv
// Buffered width down-converter: stores tagged wide flits in a FIFO and emits
// them as narrow words, LSB word first, with optional store-and-forward gating.
module flit_buffer_width_downconverter #(
  parameter int unsigned IN_FLIT_WIDTH     = 32,
  parameter int unsigned OUT_FLIT_WIDTH    = 16,
  parameter int unsigned MAX_PKT_LEN       = 10,
  parameter int unsigned STORE_AND_FORWARD = 0,
  localparam int unsigned RATIO  = IN_FLIT_WIDTH / OUT_FLIT_WIDTH,
  localparam int unsigned WCNT_W = (RATIO > 1) ? $clog2(RATIO) : 1,
  localparam int unsigned DEPTH  = 1 << $clog2(MAX_PKT_LEN + 1),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_FLIT_WIDTH-1:0]  in_flit_data,
  input  logic                      in_flit_valid,
  input  logic                      in_flit_last,
  input  logic [WCNT_W-1:0]         in_flit_words,
  output logic                      in_flit_ready,
  output logic [OUT_FLIT_WIDTH-1:0] out_flit_data,
  output logic                      out_flit_valid,
  output logic                      out_flit_last,
  input  logic                      out_flit_ready,
  output logic [CNT_W-1:0]          fill_level,
  output logic [CNT_W-1:0]          pkt_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [WCNT_W:0] RATIO_EXT = (WCNT_W + 1)'(RATIO);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // lidx holds nwords-1, so the word index wraps there rather than at 2^k
  typedef struct packed {
    logic                     last;
    logic [WCNT_W-1:0]        lidx;
    logic [IN_FLIT_WIDTH-1:0] data;
  } entry_t;

  entry_t                               mem [DEPTH];
  entry_t                               head;
  entry_t                               in_entry;
  logic [PTR_W-1:0]                     wr_ptr, rd_ptr;
  logic [WCNT_W-1:0]                    widx;
  logic [WCNT_W-1:0]                    in_lidx;
  logic [RATIO-1:0][OUT_FLIT_WIDTH-1:0] head_words;
  logic                                 push, pop, xfer, empty, full, word_last;
  logic                                 pkt_inc, pkt_dec;

  // Decode word count: 0 or anything >= RATIO means a full flit
  always_comb begin
    in_lidx = WCNT_W'(RATIO - 1);
    if (in_flit_words != '0 && {1'b0, in_flit_words} < RATIO_EXT)
      in_lidx = in_flit_words - WCNT_W'(1);
  end

  assign in_entry   = '{last: in_flit_last, lidx: in_lidx, data: in_flit_data};
  assign head       = mem[rd_ptr];
  assign head_words = head.data;

  assign empty         = (fill_level == '0);
  assign full          = (fill_level == DEPTH_C);
  assign in_flit_ready = !full;
  assign push          = in_flit_valid & in_flit_ready;

  // Full-FIFO fallback keeps an oversize packet from deadlocking in S&F mode
  assign out_flit_valid = !empty &&
                          ((STORE_AND_FORWARD == 0) || (pkt_count != '0) || full);
  assign word_last      = (widx == head.lidx);
  assign xfer           = out_flit_valid & out_flit_ready;
  assign pop            = xfer & word_last;
  assign out_flit_data  = head_words[widx];
  assign out_flit_last  = head.last & word_last & out_flit_valid;

  assign pkt_inc = push & in_flit_last;
  assign pkt_dec = pop & head.last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_count  <= '0;
      widx       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)      fill_level <= fill_level + CNT_W'(1);
      else if (!push && pop) fill_level <= fill_level - CNT_W'(1);

      if (pkt_inc && !pkt_dec)      pkt_count <= pkt_count + CNT_W'(1);
      else if (!pkt_inc && pkt_dec) pkt_count <= pkt_count - CNT_W'(1);

      if (xfer) widx <= word_last ? '0 : widx + WCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_flit_buffer_width_downconverter.sv
// Scoreboard bench for the flit down-converter: three instances cover RATIO=2,
// RATIO=3 and store-and-forward; a word-level queue model checks every output.
module tb_flit_buffer_width_downconverter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int nout_c = 0;
  logic rnd_a = 1'b0;
  logic rnd_b = 1'b0;

  // instance a: 32->16
  logic [31:0] a_in_data;  logic a_in_valid, a_in_last, a_in_ready; logic [0:0] a_in_words;
  logic [15:0] a_out_data; logic a_out_valid, a_out_last, a_out_ready;
  logic [4:0]  a_fill, a_pkt;
  // instance b: 48->16
  logic [47:0] b_in_data;  logic b_in_valid, b_in_last, b_in_ready; logic [1:0] b_in_words;
  logic [15:0] b_out_data; logic b_out_valid, b_out_last, b_out_ready;
  logic [4:0]  b_fill, b_pkt;
  // instance c: 32->16 store-and-forward
  logic [31:0] c_in_data;  logic c_in_valid, c_in_last, c_in_ready; logic [0:0] c_in_words;
  logic [15:0] c_out_data; logic c_out_valid, c_out_last, c_out_ready;
  logic [4:0]  c_fill, c_pkt;

  flit_buffer_width_downconverter u_a (
    .clk(clk), .rst(rst),
    .in_flit_data(a_in_data), .in_flit_valid(a_in_valid), .in_flit_last(a_in_last),
    .in_flit_words(a_in_words), .in_flit_ready(a_in_ready),
    .out_flit_data(a_out_data), .out_flit_valid(a_out_valid), .out_flit_last(a_out_last),
    .out_flit_ready(a_out_ready), .fill_level(a_fill), .pkt_count(a_pkt));

  flit_buffer_width_downconverter #(.IN_FLIT_WIDTH(48), .OUT_FLIT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst),
    .in_flit_data(b_in_data), .in_flit_valid(b_in_valid), .in_flit_last(b_in_last),
    .in_flit_words(b_in_words), .in_flit_ready(b_in_ready),
    .out_flit_data(b_out_data), .out_flit_valid(b_out_valid), .out_flit_last(b_out_last),
    .out_flit_ready(b_out_ready), .fill_level(b_fill), .pkt_count(b_pkt));

  flit_buffer_width_downconverter #(.STORE_AND_FORWARD(1)) u_c (
    .clk(clk), .rst(rst),
    .in_flit_data(c_in_data), .in_flit_valid(c_in_valid), .in_flit_last(c_in_last),
    .in_flit_words(c_in_words), .in_flit_ready(c_in_ready),
    .out_flit_data(c_out_data), .out_flit_valid(c_out_valid), .out_flit_last(c_out_last),
    .out_flit_ready(c_out_ready), .fill_level(c_fill), .pkt_count(c_pkt));

  // expected narrow words per instance: {last, data}
  logic [16:0] qa[$], qb[$], qc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a flit carries n = (w==0 || w>=R) ? R : w words, LSB first
  task automatic model_push(input int u, input logic [47:0] d, input int w, input logic l);
    int r;
    int n;
    logic [16:0] e;
    r = (u == 1) ? 3 : 2;
    n = (w == 0 || w >= r) ? r : w;
    for (int k = 0; k < n; k++) begin
      e = {logic'(l && (k == n - 1)), 16'(d >> (16 * k))};
      case (u)
        0: qa.push_back(e);
        1: qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  function automatic logic rdy(input int u);
    case (u)
      0: return a_in_ready;
      1: return b_in_ready;
      default: return c_in_ready;
    endcase
  endfunction

  function automatic logic outv(input int u);
    case (u)
      0: return a_out_valid;
      1: return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic int qsz(input int u);
    case (u)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic set_in(input int u, input logic v, input logic [47:0] d, input int w, input logic l);
    case (u)
      0: begin a_in_valid = v; a_in_data = d[31:0]; a_in_words = 1'(w); a_in_last = l; end
      1: begin b_in_valid = v; b_in_data = d;       b_in_words = 2'(w); b_in_last = l; end
      default: begin c_in_valid = v; c_in_data = d[31:0]; c_in_words = 1'(w); c_in_last = l; end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic push(input int u, input logic [47:0] d, input int w, input logic l);
    logic ok;
    ok = 1'b0;
    set_in(u, 1'b1, d, w, l);
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (rdy(u)) begin
        ok = 1'b1;
        model_push(u, d, w, l);
      end
    end
    if (!ok) begin
      n_vec++; n_mis++;
      $display("FAIL push_timeout%0d: got ready 0 expected ready 1", u);
    end
    @(posedge clk); #1;
    set_in(u, 1'b0, d, w, l);
  endtask

  task automatic wait_drain(input int u);
    int c;
    c = 0;
    @(negedge clk);
    while ((qsz(u) != 0 || outv(u)) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("drain_left%0d", u), 64'(qsz(u)), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic mon(input int u, input logic [16:0] act);
    logic [16:0] e;
    if (u == 2) nout_c++;
    if (qsz(u) == 0) begin
      n_vec++; n_mis++;
      $display("FAIL unexpected_word%0d: got %0h expected no output", u, act);
    end else begin
      case (u)
        0: e = qa.pop_front();
        1: e = qb.pop_front();
        default: e = qc.pop_front();
      endcase
      chk($sformatf("word%0d", u), 64'(act), 64'(e));
    end
  endtask

  always @(negedge clk) if (!rst && a_out_valid && a_out_ready) mon(0, {a_out_last, a_out_data});
  always @(negedge clk) if (!rst && b_out_valid && b_out_ready) mon(1, {b_out_last, b_out_data});
  always @(negedge clk) if (!rst && c_out_valid && c_out_ready) mon(2, {c_out_last, c_out_data});

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_a) a_out_ready = ($urandom_range(0, 3) != 0);
      if (rnd_b) b_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, '0, 0, 1'b0);
    set_in(1, 1'b0, '0, 0, 1'b0);
    set_in(2, 1'b0, '0, 0, 1'b0);
    a_out_ready = 1'b0; b_out_ready = 1'b0; c_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_valid", a_out_valid, 1'b0);
    chk("rst_last", a_out_last, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_fill", a_fill, 5'd0);
    chk("rst_pkt", a_pkt, 5'd0);
    chk("rst_valid_c", c_out_valid, 1'b0);
    @(posedge clk); #1;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;

    // single full flit, latency one cycle
    push(0, 48'hBBBBAAAA, 0, 1'b1);
    @(negedge clk);
    chk("latency_valid", a_out_valid, 1'b1);
    @(posedge clk); #1;
    wait_drain(0);

    // short flit followed by full flit
    push(0, 48'h11112222, 1, 1'b0);
    push(0, 48'h33334444, 0, 1'b1);
    wait_drain(0);

    // non power-of-two ratio
    push(1, 48'hCCCCBBBBAAAA, 0, 1'b0);
    push(1, 48'h0000FFFFEEEE, 2, 1'b1);
    wait_drain(1);

    // random traffic with random backpressure
    rnd_a = 1'b1;
    for (int i = 0; i < 150; i++) begin
      push(0, 48'($urandom), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rnd_a = 1'b0; a_out_ready = 1'b1;
    wait_drain(0);
    chk("rand_fill_a", a_fill, 5'd0);
    chk("rand_pkt_a", a_pkt, 5'd0);

    rnd_b = 1'b1;
    for (int i = 0; i < 120; i++) begin
      push(1, {16'($urandom), 32'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rnd_b = 1'b0; b_out_ready = 1'b1;
    wait_drain(1);
    chk("rand_fill_b", b_fill, 5'd0);

    // fill to DEPTH, then request push and pop together while full
    a_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(0, 48'(32'h1000 + i), 1, (i % 4) == 3);
    @(negedge clk);
    chk("full_fill", a_fill, 5'd16);
    chk("full_in_ready", a_in_ready, 1'b0);
    chk("full_pkt", a_pkt, 5'd4);
    @(posedge clk); #1;
    set_in(0, 1'b1, 48'hDEAD, 1, 1'b1);
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", a_in_ready, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 48'h0, 1, 1'b0);
    @(negedge clk);
    chk("full_pop_fill", a_fill, 5'd15);
    chk("full_pop_pkt", a_pkt, 5'd4);
    @(posedge clk); #1;
    wait_drain(0);
    chk("full_drained", a_fill, 5'd0);

    // reset with three flits buffered and widx=1
    a_out_ready = 1'b0;
    push(0, 48'hA1A1A0A0, 0, 1'b0);
    push(0, 48'hA3A3A2A2, 0, 1'b0);
    push(0, 48'hA5A5A4A4, 0, 1'b1);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    rst = 1'b1;
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", a_out_valid, 1'b0);
    chk("midrst_fill", a_fill, 5'd0);
    chk("midrst_pkt", a_pkt, 5'd0);
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    push(0, 48'h56781234, 0, 1'b1);
    wait_drain(0);

    // store-and-forward: 3-flit packet with gaps
    for (int f = 0; f < 3; f++) begin
      repeat (3) begin
        @(negedge clk);
        chk("saf_hold_valid", c_out_valid, 1'b0);
        chk("saf_hold_pkt", c_pkt, 5'd0);
      end
      @(posedge clk); #1;
      push(2, 48'(32'h0B0B_0A0A + 32'(f)), 0, f == 2);
    end
    @(negedge clk);
    chk("saf_release_valid", c_out_valid, 1'b1);
    chk("saf_release_pkt", c_pkt, 5'd1);
    @(posedge clk); #1;
    wait_drain(2);
    chk("saf_pkt_after", c_pkt, 5'd0);

    // store-and-forward: oversize packet falls back to cut-through when full
    for (int i = 0; i < 20; i++) begin
      push(2, {16'h0, 16'(2 * i + 1), 16'(2 * i)}, 0, i == 19);
      if (i < 15) begin
        @(negedge clk);
        chk("saf_big_hold", c_out_valid, 1'b0);
        @(posedge clk); #1;
      end else if (i == 15) begin
        @(negedge clk);
        chk("saf_big_fill", c_fill, 5'd16);
        chk("saf_big_start", c_out_valid, 1'b1);
        @(posedge clk); #1;
      end
    end
    wait_drain(2);
    chk("saf_words_total", 64'(nout_c), 64'd46);
    chk("saf_big_pkt", c_pkt, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
